debug_bus_master: RTL and testbench

- Byte-stream-driven initiator on the debug master port of the bus arbiter.
- A UART receiver/transmitter pair feeds it command bytes and drains its response bytes.
- It decodes HALT, RESUME, READ and WRITE commands, drives ds_cpu_halt, and issues word accesses on the dbg_* lines.
- It replaces the constant tie-offs currently applied to the arbiter's debug inputs in the microcontroller top.

---
 rtl/debug_pkg.sv | 26 ++
 rtl/debug_resp_buffer.sv | 41 ++++
 rtl/debug_bus_master.sv | 160 ++++++++++++++++
 tb/tb_debug_bus_master.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared constants and FSM state type for the byte-stream debug bus master.
package debug_pkg;

  localparam logic [7:0] CMD_HALT   = 8'h01;
  localparam logic [7:0] CMD_RESUME = 8'h02;
  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_WRITE  = 8'h04;

  localparam logic [7:0] RSP_ACK = 8'hA5;
  localparam logic [7:0] RSP_ERR = 8'hEE;

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_READ  = 2'b01;
  localparam logic [1:0] MODE_WRITE = 2'b10;
  localparam logic [1:0] REQW_WORD  = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWdata,
    StAccess,
    StCapture,
    StResp
  } state_e;

endpackage

// File: rtl/debug_resp_buffer.sv
// Response byte buffer: loaded with 1 or 4 bytes, drained LSB first over a valid/ready port.
module debug_resp_buffer (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic [31:0] i_load_word,
  input  logic        i_load_len4,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_done
);

  logic [31:0] r_data;
  logic [2:0]  r_cnt;
  logic        r_valid;
  logic        w_accept;

  assign w_accept = r_valid & i_tx_ready;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_data  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_load_word;
      r_cnt   <= i_load_len4 ? 3'd4 : 3'd1;
      r_valid <= 1'b1;
    end else if (w_accept) begin
      r_data  <= {8'h00, r_data[31:8]};
      r_cnt   <= r_cnt - 3'd1;
      r_valid <= (r_cnt > 3'd1);
    end
  end

  assign o_tx_data  = r_data[7:0];
  assign o_tx_valid = r_valid;
  assign o_done     = (r_cnt == 3'd0);

endmodule

// File: rtl/debug_bus_master.sv
// Decodes HALT/RESUME/READ/WRITE command bytes and issues word accesses on the debug bus port.
module debug_bus_master
  import debug_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_ds_cpu_halt,
  output logic [31:0] o_dbg_address,
  output logic [31:0] o_dbg_write_data,
  output logic [1:0]  o_dbg_mode,
  output logic [1:0]  o_dbg_reqw,
  output logic        o_dbg_reqs,
  input  logic [31:0] i_dbg_read_data
);

  localparam logic [31:0] TmoLast = 32'(TIMEOUT_CYCLES - 1);

  state_e      r_state, w_state_d;
  logic        r_halt, w_halt_d;
  logic        r_is_write, w_is_write_d;
  logic [1:0]  r_byte_cnt, w_byte_cnt_d;
  logic [31:0] r_addr, w_addr_d;
  logic [31:0] r_wdata, w_wdata_d;
  logic [31:0] r_tmo_cnt, w_tmo_d;
  logic        w_load;
  logic [31:0] w_load_word;
  logic        w_load_len4;
  logic        w_done;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= StIdle;
      r_halt     <= 1'b0;
      r_is_write <= 1'b0;
      r_byte_cnt <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_tmo_cnt  <= '0;
    end else begin
      r_state    <= w_state_d;
      r_halt     <= w_halt_d;
      r_is_write <= w_is_write_d;
      r_byte_cnt <= w_byte_cnt_d;
      r_addr     <= w_addr_d;
      r_wdata    <= w_wdata_d;
      r_tmo_cnt  <= w_tmo_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_halt_d     = r_halt;
    w_is_write_d = r_is_write;
    w_byte_cnt_d = r_byte_cnt;
    w_addr_d     = r_addr;
    w_wdata_d    = r_wdata;
    w_tmo_d      = '0;
    w_load       = 1'b0;
    w_load_word  = {24'h0, RSP_ACK};
    w_load_len4  = 1'b0;
    o_dbg_mode   = MODE_IDLE;
    unique case (r_state)
      StIdle: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_HALT: begin
              w_halt_d  = 1'b1;
              w_load    = 1'b1;
              w_state_d = StResp;
            end
            CMD_RESUME: begin
              w_halt_d  = 1'b0;
              w_load    = 1'b1;
              w_state_d = StResp;
            end
            CMD_READ, CMD_WRITE: begin
              w_is_write_d = (i_rx_data == CMD_WRITE);
              w_byte_cnt_d = '0;
              w_state_d    = StAddr;
            end
            default: begin
              w_load      = 1'b1;
              w_load_word = {24'h0, RSP_ERR};
              w_state_d   = StResp;
            end
          endcase
        end
      end
      StAddr, StWdata: begin
        if (i_rx_valid) begin
          // Shift right so the first (least significant) byte ends up at the bottom.
          w_byte_cnt_d = r_byte_cnt + 2'd1;
          if (r_state == StAddr) w_addr_d = {i_rx_data, r_addr[31:8]};
          else                   w_wdata_d = {i_rx_data, r_wdata[31:8]};
          if (r_byte_cnt == 2'd3) begin
            if (r_state == StAddr && r_is_write) begin
              w_state_d = StWdata;
            end else if (!r_halt) begin
              w_load      = 1'b1;
              w_load_word = {24'h0, RSP_ERR};
              w_state_d   = StResp;
            end else begin
              w_state_d = StAccess;
            end
          end
        end else if (r_tmo_cnt == TmoLast) begin
          w_state_d = StIdle;
        end else begin
          w_tmo_d = r_tmo_cnt + 32'd1;
        end
      end
      StAccess: begin
        o_dbg_mode = r_is_write ? MODE_WRITE : MODE_READ;
        if (r_is_write) begin
          w_load    = 1'b1;
          w_state_d = StResp;
        end else begin
          w_state_d = StCapture;
        end
      end
      StCapture: begin
        o_dbg_mode  = MODE_READ;
        w_load      = 1'b1;
        w_load_word = i_dbg_read_data;
        w_load_len4 = 1'b1;
        w_state_d   = StResp;
      end
      StResp: begin
        if (w_done) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  debug_resp_buffer u_resp_buffer (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (w_load),
    .i_load_word (w_load_word),
    .i_load_len4 (w_load_len4),
    .o_tx_data   (o_tx_data),
    .o_tx_valid  (o_tx_valid),
    .i_tx_ready  (i_tx_ready),
    .o_done      (w_done)
  );

  assign o_ds_cpu_halt    = r_halt;
  assign o_dbg_address    = r_addr;
  assign o_dbg_write_data = r_wdata;
  assign o_dbg_reqw       = REQW_WORD;
  assign o_dbg_reqs       = 1'b0;

endmodule

// File: tb/tb_debug_bus_master.sv
// Directed bench for debug_bus_master: command decode, bus timing, tx handshake, timeout, reset.
module tb_debug_bus_master;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        ds_cpu_halt;
  logic [31:0] dbg_address;
  logic [31:0] dbg_write_data;
  logic [1:0]  dbg_mode;
  logic [1:0]  dbg_reqw;
  logic        dbg_reqs;
  logic [31:0] dbg_read_data;

  int total = 0;
  int bad   = 0;

  // Monitor state, sampled on the falling edge.
  logic [7:0] tx_q[$];
  int wr_cyc = 0;
  int rd_cyc = 0;

  debug_bus_master #(
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_rx_data        (rx_data),
    .i_rx_valid       (rx_valid),
    .o_tx_data        (tx_data),
    .o_tx_valid       (tx_valid),
    .i_tx_ready       (tx_ready),
    .o_ds_cpu_halt    (ds_cpu_halt),
    .o_dbg_address    (dbg_address),
    .o_dbg_write_data (dbg_write_data),
    .o_dbg_mode       (dbg_mode),
    .o_dbg_reqw       (dbg_reqw),
    .o_dbg_reqs       (dbg_reqs),
    .i_dbg_read_data  (dbg_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dbg_mode == 2'b10) wr_cyc++;
    if (dbg_mode == 2'b01) rd_cyc++;
    if (tx_valid && tx_ready && reset) tx_q.push_back(tx_data);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one byte for exactly one rising edge; returns 1 time unit after that edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic clear_mon();
    tx_q.delete();
    wr_cyc = 0;
    rd_cyc = 0;
  endtask

  task automatic test_reset();
    int mode_bad = 0;
    reset = 1'b0;
    step(3);
    reset = 1'b1;
    clear_mon();
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (dbg_mode !== 2'b00 || tx_valid !== 1'b0 || ds_cpu_halt !== 1'b0) mode_bad++;
    end
    total++;
    if (mode_bad !== 0) begin
      bad++;
      $display("FAIL reset_idle: %0d bad cycles, required 0", mode_bad);
    end
    total++;
    if (dbg_address !== 32'h0 || dbg_write_data !== 32'h0 || tx_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_regs: addr=%h wdata=%h txd=%h, required all zero",
               dbg_address, dbg_write_data, tx_data);
    end
    total++;
    if (dbg_reqw !== 2'b10 || dbg_reqs !== 1'b0) begin
      bad++;
      $display("FAIL reset_req: reqw=%b reqs=%b, required 10/0", dbg_reqw, dbg_reqs);
    end
  endtask

  task automatic test_halt_write();
    clear_mon();
    send_byte(8'h01);
    total++;
    if (ds_cpu_halt !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
      bad++;
      $display("FAIL halt: halt=%b txv=%b txd=%h, required 1/1/a5", ds_cpu_halt, tx_valid, tx_data);
    end
    step(3);
    send_byte(8'h04);
    send_byte(8'h10);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'hEF);
    send_byte(8'hBE);
    send_byte(8'hAD);
    send_byte(8'hDE);
    total++;
    if (dbg_mode !== 2'b10 || dbg_address !== 32'h10 || dbg_write_data !== 32'hDEADBEEF
        || tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL write_access: mode=%b addr=%h wdata=%h txv=%b, required 10/10/deadbeef/0",
               dbg_mode, dbg_address, dbg_write_data, tx_valid);
    end
    step(1);
    total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA5 || dbg_mode !== 2'b00) begin
      bad++;
      $display("FAIL write_reply: txv=%b txd=%h mode=%b, required 1/a5/00",
               tx_valid, tx_data, dbg_mode);
    end
    step(4);
    total++;
    if (wr_cyc !== 1 || rd_cyc !== 0 || tx_q.size() !== 2) begin
      bad++;
      $display("FAIL write_counts: wr=%0d rd=%0d tx=%0d, required 1/0/2",
               wr_cyc, rd_cyc, tx_q.size());
    end
  endtask

  task automatic test_read_backpressure();
    int unstable = 0;
    int waited = 0;
    clear_mon();
    tx_ready = 1'b0;
    send_byte(8'h03);
    send_byte(8'h10);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    total++;
    if (dbg_mode !== 2'b01 || dbg_address !== 32'h10) begin
      bad++;
      $display("FAIL read_access: mode=%b addr=%h, required 01/00000010", dbg_mode, dbg_address);
    end
    step(1);
    total++;
    if (dbg_mode !== 2'b01 || dbg_address !== 32'h10 || tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL read_capture: mode=%b addr=%h txv=%b, required 01/00000010/0",
               dbg_mode, dbg_address, tx_valid);
    end
    step(1);
    total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hEF || dbg_mode !== 2'b00) begin
      bad++;
      $display("FAIL read_first: txv=%b txd=%h mode=%b, required 1/ef/00",
               tx_valid, tx_data, dbg_mode);
    end
    tx_ready = 1'b1;
    step(1);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (tx_valid !== 1'b1 || tx_data !== 8'hBE) unstable++;
    end
    total++;
    if (unstable !== 0) begin
      bad++;
      $display("FAIL read_stall: %0d unstable cycles, required 0", unstable);
    end
    tx_ready = 1'b1;
    while (tx_q.size() < 4 && waited < 20) begin
      step(1);
      waited++;
    end
    step(2);
    total++;
    if (tx_q.size() !== 4) begin
      bad++;
      $display("FAIL read_len: got %0d bytes, required 4", tx_q.size());
    end else begin
      total++;
      if (tx_q[0] !== 8'hEF || tx_q[1] !== 8'hBE || tx_q[2] !== 8'hAD || tx_q[3] !== 8'hDE) begin
        bad++;
        $display("FAIL read_bytes: got %h %h %h %h, required ef be ad de",
                 tx_q[0], tx_q[1], tx_q[2], tx_q[3]);
      end
    end
    total++;
    if (rd_cyc !== 2 || wr_cyc !== 0) begin
      bad++;
      $display("FAIL read_mode_cycles: rd=%0d wr=%0d, required 2/0", rd_cyc, wr_cyc);
    end
  endtask

  task automatic test_not_halted();
    send_byte(8'h02);
    step(4);
    clear_mon();
    total++;
    if (ds_cpu_halt !== 1'b0) begin
      bad++;
      $display("FAIL resume: halt=%b, required 0", ds_cpu_halt);
    end
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h40);
    send_byte(8'h00);
    send_byte(8'h00);
    total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hEE) begin
      bad++;
      $display("FAIL unhalted_read: txv=%b txd=%h, required 1/ee", tx_valid, tx_data);
    end
    step(4);
    send_byte(8'h7F);
    total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hEE) begin
      bad++;
      $display("FAIL bad_opcode: txv=%b txd=%h, required 1/ee", tx_valid, tx_data);
    end
    step(4);
    total++;
    if (tx_q.size() !== 2 || rd_cyc !== 0 || wr_cyc !== 0) begin
      bad++;
      $display("FAIL unhalted_counts: tx=%0d rd=%0d wr=%0d, required 2/0/0",
               tx_q.size(), rd_cyc, wr_cyc);
    end
  endtask

  task automatic test_timeout();
    send_byte(8'h01);
    step(4);
    clear_mon();
    send_byte(8'h04);
    send_byte(8'h00);
    step(20);
    total++;
    if (tx_q.size() !== 0 || tx_valid !== 1'b0 || wr_cyc !== 0 || ds_cpu_halt !== 1'b1) begin
      bad++;
      $display("FAIL timeout_quiet: tx=%0d txv=%b wr=%0d halt=%b, required 0/0/0/1",
               tx_q.size(), tx_valid, wr_cyc, ds_cpu_halt);
    end
    send_byte(8'h02);
    total++;
    if (ds_cpu_halt !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
      bad++;
      $display("FAIL timeout_resume: halt=%b txv=%b txd=%h, required 0/1/a5",
               ds_cpu_halt, tx_valid, tx_data);
    end
    step(4);
  endtask

  task automatic test_async_reset();
    send_byte(8'h01);
    step(4);
    send_byte(8'h03);
    send_byte(8'h20);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    step(1);
    total++;
    if (dbg_mode !== 2'b01) begin
      bad++;
      $display("FAIL capture_setup: mode=%b, required 01", dbg_mode);
    end
    reset = 1'b0;
    #1;
    total++;
    if (dbg_mode !== 2'b00 || ds_cpu_halt !== 1'b0 || tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: mode=%b halt=%b txv=%b, required 00/0/0",
               dbg_mode, ds_cpu_halt, tx_valid);
    end
    step(2);
    reset = 1'b1;
    step(2);
    send_byte(8'h01);
    total++;
    if (ds_cpu_halt !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
      bad++;
      $display("FAIL post_reset_halt: halt=%b txv=%b txd=%h, required 1/1/a5",
               ds_cpu_halt, tx_valid, tx_data);
    end
    step(4);
  endtask

  initial begin
    reset         = 1'b0;
    rx_data       = 8'h00;
    rx_valid      = 1'b0;
    tx_ready      = 1'b1;
    dbg_read_data = 32'hDEADBEEF;
    test_reset();
    test_halt_write();
    test_read_backpressure();
    test_not_halted();
    test_timeout();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
